nos_dac_mc_serializer: RTL and testbench

NOS_DAC_MC_SERIALIZER -- requirements
Module: nos_dac_mc_serializer

---
 rtl/common.sv | 30 +++
 rtl/nos_dac_shreg.sv | 39 +++
 rtl/nos_dac_mc_serializer.sv | 114 +++++++++++
 tb/tb_nos_dac_mc_serializer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared constants and types for the NOS DAC serializer family.
// Word-length selection, I2S word width and the serializer state encoding.
package common;
    localparam int I2S_BITS     = 32;
    localparam int NOS_MAX_BITS = 24;
    localparam int NOS_BITNUM   = 2;

    typedef enum logic [NOS_BITNUM-1:0] {
        NOS16 = 2'd0,
        NOS18 = 2'd1,
        NOS20 = 2'd2,
        NOS24 = 2'd3
    } nos_bitnum_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } ser_state_t;

    function automatic logic [4:0] nos_len(input logic [NOS_BITNUM-1:0] sel);
        case (sel)
            NOS16:   nos_len = 5'd16;
            NOS18:   nos_len = 5'd18;
            NOS20:   nos_len = 5'd20;
            default: nos_len = 5'd24;
        endcase
    endfunction
endpackage

// File: rtl/nos_dac_shreg.sv
// Per-channel load/shift register: keeps the top N bits of a left-justified word.
// Load/shift are strobes from the shared FSM; sdo is combinational from the register.
module nos_dac_shreg
    import common::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                load,
    input  logic                shift,
    input  logic [I2S_BITS-1:0] word,
    input  logic [4:0]          load_n,
    input  logic                load_ofs,
    input  logic                lsb_first,
    input  logic [4:0]          cur_n,
    output logic                sdo
);
    logic [NOS_MAX_BITS-1:0] sr;
    logic [NOS_MAX_BITS-1:0] load_val;

    // Right-align the top N bits; offset binary flips the word's sign bit.
    always_comb begin
        load_val = NOS_MAX_BITS'(word >> (6'(I2S_BITS) - {1'b0, load_n}));
        if (load_ofs) begin
            load_val[load_n - 5'd1] = ~load_val[load_n - 5'd1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_val;
        end else if (shift) begin
            sr <= lsb_first ? (sr >> 1) : (sr << 1);
        end
    end

    assign sdo = lsb_first ? sr[0] : sr[cur_n - 5'd1];
endmodule

// File: rtl/nos_dac_mc_serializer.sv
// Multi-channel NOS DAC serializer: one frame of FRAME_CYCLES clk per accepted sample set.
// Data shifts out in the last N cycles of the frame, then one le cycle; ready only in IDLE/LATCH.
module nos_dac_mc_serializer
    import common::*;
#(
    parameter int NUM_CH       = 2,
    parameter int FRAME_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH*I2S_BITS-1:0] data,
    input  logic                       valid,
    output logic                       ready,
    input  logic [NOS_BITNUM-1:0]      nos_bitnum,
    input  logic                       bck_cont,
    input  logic                       lsb_first,
    input  logic                       offset_bin,
    input  logic                       mute,
    input  logic                       le_pol,
    output logic                       bck,
    output logic [NUM_CH-1:0]          data_out,
    output logic                       le,
    output logic                       underrun
);
    ser_state_t        state, state_d;
    logic [7:0]        cnt, cnt_d;
    logic [4:0]        n_q, n_in;
    logic              lsb_q;
    logic              load, shift;
    logic [NUM_CH-1:0] sdo;

    assign n_in = nos_len(nos_bitnum);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            n_q   <= 5'd16;
            lsb_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load) begin
                n_q   <= n_in;
                lsb_q <= lsb_first;
            end
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        load     = 1'b0;
        shift    = 1'b0;
        ready    = 1'b0;
        underrun = 1'b0;
        le       = ~le_pol;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    load    = 1'b1;
                    cnt_d   = 8'(FRAME_CYCLES - 1);
                    state_d = (8'(FRAME_CYCLES - 1) == 8'(n_in)) ? SHIFT : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt - 8'd1;
                if (cnt == 8'(n_q) + 8'd1) state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt - 8'd1;
                shift = 1'b1;
                if (cnt == 8'd1) state_d = LATCH;
            end
            LATCH: begin
                ready = 1'b1;
                le    = le_pol;
                if (valid) begin
                    load    = 1'b1;
                    cnt_d   = 8'(FRAME_CYCLES - 1);
                    state_d = (8'(FRAME_CYCLES - 1) == 8'(n_in)) ? SHIFT : WAIT;
                end else begin
                    state_d  = IDLE;
                    underrun = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        nos_dac_shreg u_shreg (
            .clk       (clk),
            .resetn    (resetn),
            .load      (load),
            .shift     (shift),
            .word      (data[k*I2S_BITS +: I2S_BITS]),
            .load_n    (n_in),
            .load_ofs  (offset_bin),
            .lsb_first (lsb_q),
            .cur_n     (n_q),
            .sdo       (sdo[k])
        );
    end

    // mute gates only the serial lines; framing and le carry on untouched.
    always_comb begin
        data_out = '0;
        if (state == SHIFT && !mute) data_out = sdo;
    end

    assign bck = resetn & (bck_cont | (state == SHIFT) | (state == LATCH)) & ~clk;
endmodule

// File: tb/tb_nos_dac_mc_serializer.sv
// Randomized and directed bench for nos_dac_mc_serializer with a frame-position reference model.
module tb_nos_dac_mc_serializer;
    import common::*;

    localparam int NUM_CH = 2;
    localparam int F      = 64;

    logic                       clk = 1'b0;
    logic                       resetn;
    logic [NUM_CH*I2S_BITS-1:0] data;
    logic                       valid;
    logic                       ready;
    logic [NOS_BITNUM-1:0]      nos_bitnum;
    logic                       bck_cont, lsb_first, offset_bin, mute, le_pol;
    logic                       bck, le, underrun;
    logic [NUM_CH-1:0]          data_out;

    always #5 clk = ~clk;

    nos_dac_mc_serializer #(.NUM_CH(NUM_CH), .FRAME_CYCLES(F)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .nos_bitnum (nos_bitnum),
        .bck_cont   (bck_cont),
        .lsb_first  (lsb_first),
        .offset_bin (offset_bin),
        .mute       (mute),
        .le_pol     (le_pol),
        .bck        (bck),
        .data_out   (data_out),
        .le         (le),
        .underrun   (underrun)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model: frame position 1..F counted from the cycle after the transfer.
    bit          m_act = 1'b0;
    int          m_pos = 0;
    int          m_n   = 16;
    bit          m_lsb = 1'b0;
    logic [23:0] m_v [NUM_CH];

    logic [23:0] col [NUM_CH];
    int          bitcnt    = 0;
    int          underruns = 0;
    int          le_cyc [$];
    int          xfer_cyc [$];

    function automatic int len_of(input logic [1:0] s);
        case (s)
            2'd0:    return 16;
            2'd1:    return 18;
            2'd2:    return 20;
            default: return 24;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_outputs();
        logic              shifting, latch, e_rdy, e_le, e_ur, e_bck;
        logic [NUM_CH-1:0] e_do;
        int                i;
        shifting = m_act && (m_pos >= F - m_n) && (m_pos <= F - 1);
        latch    = m_act && (m_pos == F);
        i        = m_pos - (F - m_n);
        e_do     = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (shifting && !mute) e_do[ch] = m_lsb ? m_v[ch][i] : m_v[ch][m_n-1-i];
        end
        e_rdy = !m_act || latch;
        e_le  = latch ? le_pol : !le_pol;
        e_ur  = latch && !valid;
        e_bck = resetn && (bck_cont || shifting || latch);
        chk("ready", {31'd0, ready}, {31'd0, e_rdy});
        chk("le", {31'd0, le}, {31'd0, e_le});
        chk("underrun", {31'd0, underrun}, {31'd0, e_ur});
        chk("data_out", {30'd0, data_out}, {30'd0, e_do});
        chk("bck", {31'd0, bck}, {31'd0, e_bck});
        if (shifting) begin
            for (int ch = 0; ch < NUM_CH; ch++) col[ch] = {col[ch][22:0], data_out[ch]};
            bitcnt++;
        end
        if (le === le_pol) le_cyc.push_back(cyc);
        if (underrun === 1'b1) underruns++;
    endtask

    task automatic model_edge();
        logic [31:0] w, v;
        if (!resetn) begin
            m_act = 1'b0;
            return;
        end
        if (valid && (!m_act || m_pos == F)) begin
            m_act = 1'b1;
            m_pos = 1;
            m_n   = len_of(nos_bitnum);
            m_lsb = lsb_first;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                w = data[ch*32 +: 32];
                v = w >> (32 - m_n);
                if (offset_bin) v[m_n-1] = ~v[m_n-1];
                m_v[ch] = v[23:0];
            end
            xfer_cyc.push_back(cyc);
        end else if (m_act) begin
            if (m_pos == F) m_act = 1'b0;
            else m_pos++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_col();
        for (int ch = 0; ch < NUM_CH; ch++) col[ch] = '0;
        bitcnt    = 0;
        underruns = 0;
    endtask

    initial begin
        int s_le, s_x;
        resetn = 1'b0; valid = 1'b0; data = '0; nos_bitnum = 2'd3;
        bck_cont = 1'b1; lsb_first = 1'b0; offset_bin = 1'b0; mute = 1'b0; le_pol = 1'b1;
        #1;
        run(3);
        resetn = 1'b1; bck_cont = 1'b0;
        run(2);

        // NOS24 MSB first, single transfer
        clear_col();
        data = {32'h3C3C3C00 | 32'($urandom_range(0, 255)), 32'hA5A5A500 | 32'($urandom_range(0, 255))};
        valid = 1'b1;
        s_le = le_cyc.size();
        cycle();
        valid = 1'b0;
        data = {$urandom, $urandom};
        run(70);
        chk("s1_left_bits", {8'd0, col[0]}, 32'h00A5A5A5);
        chk("s1_right_bits", {8'd0, col[1]}, 32'h003C3C3C);
        chk("s1_bitcnt", bitcnt, 24);
        chk("s1_le_cycle", le_cyc[s_le] - xfer_cyc[xfer_cyc.size()-1], 64);
        chk("s1_underruns", underruns, 1);

        // NOS16 continuous valid, 4 frames
        clear_col();
        nos_bitnum = 2'd0; valid = 1'b1;
        s_le = le_cyc.size(); s_x = xfer_cyc.size();
        for (int c = 0; c < 400; c++) begin
            data = {$urandom, $urandom};
            cycle();
            if (xfer_cyc.size() - s_x >= 4) valid = 1'b0;
        end
        chk("s2_le_count", le_cyc.size() - s_le, 4);
        for (int i = 1; i < 4; i++) chk("s2_le_period", le_cyc[s_le+i] - le_cyc[s_le+i-1], 64);
        chk("s2_bitcnt", bitcnt, 64);
        chk("s2_underruns", underruns, 1);

        // NOS18 LSB first, offset binary, 0x80000000 -> all zeros
        clear_col();
        nos_bitnum = 2'd1; lsb_first = 1'b1; offset_bin = 1'b1;
        data = {$urandom, 32'h80000000};
        valid = 1'b1;
        cycle();
        valid = 1'b0; lsb_first = 1'b0; offset_bin = 1'b0;
        run(70);
        chk("s3_bits", {8'd0, col[0]}, 32'd0);
        chk("s3_bitcnt", bitcnt, 18);

        // NOS20 frame with word length switched to NOS24 mid-SHIFT
        clear_col();
        nos_bitnum = 2'd2; valid = 1'b1; s_x = xfer_cyc.size();
        for (int c = 0; c < 200; c++) begin
            data = {$urandom, $urandom};
            cycle();
            if (c == 50) nos_bitnum = 2'd3;
            if (xfer_cyc.size() - s_x >= 2) valid = 1'b0;
        end
        chk("s4_bitcnt", bitcnt, 44);

        // mute throughout a frame
        clear_col();
        mute = 1'b1; valid = 1'b1; bck_cont = 1'b0;
        data = {$urandom, $urandom} | {32'h80000000, 32'h80000000};
        s_le = le_cyc.size();
        cycle();
        valid = 1'b0;
        run(70);
        mute = 1'b0;
        chk("s5_muted_bits", {8'd0, col[0] | col[1]}, 32'd0);
        chk("s5_le_count", le_cyc.size() - s_le, 1);

        // reset in cycle 50 of a frame
        nos_bitnum = 2'd3; valid = 1'b1; bck_cont = 1'b1;
        data = {$urandom, $urandom};
        cycle();
        valid = 1'b0;
        run(49);
        #2 resetn = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_le", {31'd0, le ^ le_pol}, 32'd1);
        chk("rst_data_out", {30'd0, data_out}, 32'd0);
        chk("rst_bck", {31'd0, bck}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        m_act = 1'b0;
        run(2);
        resetn = 1'b1;
        s_le = le_cyc.size();
        run(70);
        chk("rst_no_le", le_cyc.size() - s_le, 0);

        // randomized traffic with mid-frame control changes
        for (int c = 0; c < 800; c++) begin
            data       = {$urandom, $urandom};
            valid      = ($urandom_range(0, 7) != 0);
            nos_bitnum = 2'($urandom_range(0, 3));
            lsb_first  = 1'($urandom_range(0, 1));
            offset_bin = 1'($urandom_range(0, 1));
            mute       = ($urandom_range(0, 5) == 0);
            bck_cont   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) le_pol = ~le_pol;
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
